acondicionador_botones: RTL and testbench
=========================================

ACONDICIONADOR_BOTONES -- requirements
Module: acondicionador_botones

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, consecutive stable cycles required to accept a level change; legal range 2..1023.
REQ-002 Parameter REPEAT_CYCLES, default 50, auto-repeat period in cycles; legal range 2..65535; used only under REQ-030.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_sleep_n  input  1  raw Sleep pushbutton, asynchronous, active-low.
REQ-006 btn_awake_n  input  1  raw Awake pushbutton, asynchronous, active-low.
REQ-007 btn_feed_n  input  1  raw Feed pushbutton, asynchronous, active-low.
REQ-008 btn_play_n  input  1  raw Play pushbutton, asynchronous, active-low.
REQ-009 giro_raw  input  1  raw tilt sensor, asynchronous, active-high.
REQ-010 botonSleep, botonAwake, botonFeed, botonPlay  output  1 each  single-cycle press pulses, active-high, for the pet state machine.
REQ-011 giro  output  1  debounced tilt level, active-high.

Function
REQ-012 Each of the five channels SHALL be processed by an independent, identical pipeline: 2-flop synchronizer, debounce counter, stable-level register.
REQ-013 Synchronizer output s SHALL be the raw input delayed by exactly two clk edges.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
REQ-015 While s equals the stable level, the counter SHALL be 0.
REQ-016 While s differs from the stable level, the counter SHALL increment by 1 per cycle; any single cycle with s equal to the stable level (bounce) SHALL clear it to 0.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and s still differs, the stable level SHALL flip at that edge and the counter SHALL clear.
REQ-018 Net latency: a clean raw transition sampled at edge N SHALL change the stable level at edge N+1+DEBOUNCE_CYCLES.
REQ-019 Per button channel, states SHALL be RELEASED, PRESS_QUAL, PRESSED, RELEASE_QUAL; transitions per REQ-015..017 (RELEASED->PRESS_QUAL on s=0, PRESS_QUAL->PRESSED on qualify, PRESS_QUAL->RELEASED on bounce; mirrored for release).
REQ-020 A button pulse output SHALL be high for exactly one cycle, the cycle after the RELEASED-or-PRESS_QUAL -> PRESSED transition edge, and low otherwise.
REQ-021 Release SHALL never produce a pulse.
REQ-022 giro SHALL equal the giro channel stable level (no pulse generation).
REQ-023 Simultaneous presses on several channels SHALL each produce their own pulse, possibly in the same cycle; no priority or masking.
REQ-024 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.

Reset
REQ-025 While rst=1 at an edge: all outputs 0, counters 0, button stable levels and synchronizer flops = released (1), giro stable level and flops = 0, all FSMs = RELEASED, repeat counters 0.
REQ-026 Reset SHALL override any in-progress qualification; a button held through reset deassertion SHALL be re-qualified as a new press and pulse after full debounce latency.
REQ-027 No output SHALL pulse in the cycle rst deasserts.

Configuration
REQ-028 Macro AUTO_REPEAT_EN SHALL select auto-repeat for botonFeed and botonPlay only.
REQ-029 Without AUTO_REPEAT_EN: exactly one pulse per qualified press regardless of hold time; no repeat counters synthesized.
REQ-030 With AUTO_REPEAT_EN: while Feed/Play stays PRESSED, an additional one-cycle pulse SHALL occur every REPEAT_CYCLES cycles after the initial pulse; repeat counter clears on leaving PRESSED; Sleep and Awake unaffected.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-031 rst=1 for 5 cycles, all raw inputs idle -> all outputs 0 during and after reset; no pulse on deassertion.
REQ-032 btn_feed_n 1->0 sampled at edge N, held 30 cycles -> botonFeed high only in cycle after edge N+5; without macro no further pulse; with macro further pulses after edges N+15, N+25.
REQ-033 btn_sleep_n low 3 cycles, high 1, low 3 (bounce) -> botonSleep never asserts; then held low 4+ cycles -> single pulse.
REQ-034 btn_sleep_n and btn_play_n fall at same edge N -> botonSleep and botonPlay both pulse in same cycle after edge N+5.
REQ-035 giro_raw 0->1 at edge N -> giro rises after edge N+5; 2-cycle 0 glitch later -> giro stays 1.
REQ-036 btn_awake_n held low, rst pulsed 1 cycle mid-press -> botonAwake pulses again after full debounce from reset release.

Source files
------------

// File: rtl/acondicionador_botones.sv
// ---------------------------------------------------------------------------
// acondicionador_botones
//   Conditions four raw active-low pushbuttons and one raw tilt sensor for
//   the pet state machine. Each channel runs an independent pipeline made of
//   a 2-flop synchronizer, a debounce counter and a stable-level register.
//   Buttons produce a single-cycle press pulse. The tilt sensor produces a
//   debounced level.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When defined, Feed and Play emit an extra pulse every REPEAT_CYCLES
//     cycles while they stay pressed. Sleep and Awake are unaffected.
//     When undefined, no repeat counters are built.
//
//   Ports
//     clk          in   system clock, rising edge
//     rst          in   synchronous active-high reset
//     btn_sleep_n  in   raw Sleep button, async, active-low
//     btn_awake_n  in   raw Awake button, async, active-low
//     btn_feed_n   in   raw Feed button, async, active-low
//     btn_play_n   in   raw Play button, async, active-low
//     giro_raw     in   raw tilt sensor, async, active-high
//     botonSleep   out  Sleep press pulse (1 cycle)
//     botonAwake   out  Awake press pulse (1 cycle)
//     botonFeed    out  Feed press pulse (1 cycle, optional auto-repeat)
//     botonPlay    out  Play press pulse (1 cycle, optional auto-repeat)
//     giro         out  debounced tilt level
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// acondicionador_boton
//   One pushbutton channel: synchronizer, debounce FSM, and press pulse.
//   Ports: clk, rst, raw_n (raw active-low button), pulse (press pulse).
// ---------------------------------------------------------------------------
module acondicionador_boton #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned REPEAT_CYCLES   = 50,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic pulse
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_QUAL,
        PRESSED,
        RELEASE_QUAL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          s;
    logic          repeat_hit;

    // Two-flop synchronizer, idles at the released level (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= raw_n;
            s     <= sync1;
        end
    end

    // Debounce FSM. The qualification states carry the running count of
    // consecutive cycles with s opposite to the stable level, so entering a
    // qualification state already counts the first differing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RELEASED;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= repeat_hit;
            case (state)
                RELEASED: begin
                    if (!s) begin
                        state <= PRESS_QUAL;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_QUAL: begin
                    if (s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state <= RELEASE_QUAL;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                RELEASE_QUAL: begin
                    if (!s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int unsigned   RW       = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0] rep_cnt;

            // Counts from the initial pulse; restarts whenever the channel
            // is not in PRESSED, including the edge that enters PRESSED.
            always_ff @(posedge clk) begin
                if (rst || state != PRESSED) begin
                    rep_cnt <= '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end

            always_comb begin
                repeat_hit = (state == PRESSED) && (rep_cnt == REP_LAST);
            end
        end else begin : g_no_repeat
            always_comb begin
                repeat_hit = 1'b0;
            end
        end
    endgenerate
`else
    always_comb begin
        repeat_hit = 1'b0;
    end
`endif

endmodule

// ---------------------------------------------------------------------------
// acondicionador_nivel
//   Level channel: synchronizer, debounce counter, stable-level register.
//   Ports: clk, rst, raw (raw active-high input), level (debounced level).
// ---------------------------------------------------------------------------
module acondicionador_nivel #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          sync1;
    logic          s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            if (s == level) begin
                cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// acondicionador_botones (top)
// ---------------------------------------------------------------------------
module acondicionador_botones #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned REPEAT_CYCLES   = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sleep_n,
    input  logic btn_awake_n,
    input  logic btn_feed_n,
    input  logic btn_play_n,
    input  logic giro_raw,
    output logic botonSleep,
    output logic botonAwake,
    output logic botonFeed,
    output logic botonPlay,
    output logic giro
);

`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_FP = 1'b1;
`else
    localparam bit REPEAT_FP = 1'b0;
`endif

    acondicionador_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_sleep (
        .clk   (clk),
        .rst   (rst),
        .raw_n (btn_sleep_n),
        .pulse (botonSleep)
    );

    acondicionador_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_awake (
        .clk   (clk),
        .rst   (rst),
        .raw_n (btn_awake_n),
        .pulse (botonAwake)
    );

    acondicionador_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (REPEAT_FP)
    ) u_feed (
        .clk   (clk),
        .rst   (rst),
        .raw_n (btn_feed_n),
        .pulse (botonFeed)
    );

    acondicionador_boton #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (REPEAT_FP)
    ) u_play (
        .clk   (clk),
        .rst   (rst),
        .raw_n (btn_play_n),
        .pulse (botonPlay)
    );

    acondicionador_nivel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_giro (
        .clk   (clk),
        .rst   (rst),
        .raw   (giro_raw),
        .level (giro)
    );

endmodule

// File: tb/tb_acondicionador_botones.sv
// ---------------------------------------------------------------------------
// tb_acondicionador_botones
//   Directed bench for acondicionador_botones with DEBOUNCE_CYCLES=4 and
//   REPEAT_CYCLES=10. Each loop index k names the clock edge that first
//   samples the stimulus (edge 0); outputs are observed 1 time unit after
//   every edge as the vector {Sleep, Awake, Feed, Play, giro}.
// ---------------------------------------------------------------------------
module tb_acondicionador_botones;

    logic clk = 1'b0;
    logic rst;
    logic btn_sleep_n, btn_awake_n, btn_feed_n, btn_play_n, giro_raw;
    logic botonSleep, botonAwake, botonFeed, botonPlay, giro;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    acondicionador_botones #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_sleep_n (btn_sleep_n),
        .btn_awake_n (btn_awake_n),
        .btn_feed_n  (btn_feed_n),
        .btn_play_n  (btn_play_n),
        .giro_raw    (giro_raw),
        .botonSleep  (botonSleep),
        .botonAwake  (botonAwake),
        .botonFeed   (botonFeed),
        .botonPlay   (botonPlay),
        .giro        (giro)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] obs();
        return {botonSleep, botonAwake, botonFeed, botonPlay, giro};
    endfunction

    initial begin
        rst         = 1'b1;
        btn_sleep_n = 1'b1;
        btn_awake_n = 1'b1;
        btn_feed_n  = 1'b1;
        btn_play_n  = 1'b1;
        giro_raw    = 1'b0;

        // Reset held 5 cycles, then idle after deassertion.
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("reset[%0d]", k), obs(), 5'b00000);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val($sformatf("post_reset[%0d]", k), obs(), 5'b00000);
        end

        // Feed held 30 cycles: pulse at edge 5, repeats at 15/25 if enabled.
        for (int k = 0; k < 45; k++) begin
            logic [4:0] exp;
            btn_feed_n = (k >= 30);
            tick();
            exp = '0;
            exp[2] = (k == 5) || (REP && (k == 15 || k == 25));
            check_val($sformatf("feed_hold[%0d]", k), obs(), exp);
        end

        // Sleep bounce: L L L H L L L H then held low; one pulse at 8+5.
        for (int k = 0; k < 26; k++) begin
            logic [4:0] exp;
            btn_sleep_n = !((k <= 2) || (k >= 4 && k <= 6) || (k >= 8 && k <= 15));
            tick();
            exp = '0;
            exp[4] = (k == 13);
            check_val($sformatf("sleep_bounce[%0d]", k), obs(), exp);
        end

        // Sleep and Play pressed together: both pulse at edge 5.
        for (int k = 0; k < 20; k++) begin
            logic [4:0] exp;
            btn_sleep_n = (k >= 10);
            btn_play_n  = (k >= 10);
            tick();
            exp = '0;
            exp[4] = (k == 5);
            exp[1] = (k == 5);
            check_val($sformatf("simul[%0d]", k), obs(), exp);
        end

        // Tilt: rise at 5, 2-cycle glitch ignored, fall at 21+5.
        for (int k = 0; k < 31; k++) begin
            logic [4:0] exp;
            giro_raw = (k < 10) || (k >= 12 && k < 21);
            tick();
            exp = '0;
            exp[0] = (k >= 5) && (k < 26);
            check_val($sformatf("giro[%0d]", k), obs(), exp);
        end

        // Awake held; reset pulsed at edge 10 re-qualifies from edge 11.
        for (int k = 0; k < 25; k++) begin
            logic [4:0] exp;
            btn_awake_n = 1'b0;
            rst = (k == 10);
            tick();
            exp = '0;
            exp[3] = (k == 5) || (k == 16);
            check_val($sformatf("awake_rst[%0d]", k), obs(), exp);
        end
        rst = 1'b0;
        btn_awake_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val($sformatf("awake_release[%0d]", k), obs(), 5'b00000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
